// File: rtl/cache_fill_controller.sv
// cache_fill_controller: I/D-cache miss arbiter (D priority) that issues 8 word reads, streams the returns into the owner's data array, then writes its tag; ports: i_*cache_miss/_addr requests, i_mem_* returns, o_mem_* reads, o_fill_* and o_*cache_*_we array writes, o_*_fill_done pulses, o_busy/o_grant_d status
module cache_fill_controller #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_icache_miss,
  input  logic [ADDR_W-1:0] i_icache_miss_addr,
  input  logic              i_dcache_miss,
  input  logic [ADDR_W-1:0] i_dcache_miss_addr,
  input  logic              i_mem_data_valid,
  input  logic [15:0]       i_mem_data_in,
  output logic              o_mem_enable,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_fill_data,
  output logic [7:0]        o_fill_word_en,
  output logic [5:0]        o_fill_index,
  output logic [6:0]        o_fill_tag,
  output logic              o_icache_data_we,
  output logic              o_dcache_data_we,
  output logic              o_icache_tag_we,
  output logic              o_dcache_tag_we,
  output logic              o_icache_fill_done,
  output logic              o_dcache_fill_done,
  output logic              o_busy,
  output logic              o_grant_d
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_TAG} state_t;
  state_t      r_state, w_next;
  logic [11:0] r_blk;
  logic        r_grant_d;
  logic [2:0]  r_issue_cnt, r_recv_cnt;
  logic        w_rx, w_last_rx, w_tag, w_start, w_unused;
  assign w_rx      = i_mem_data_valid && (r_state == S_ISSUE || r_state == S_DRAIN);
  assign w_last_rx = w_rx && r_recv_cnt == 3'd7;
  assign w_tag     = r_state == S_TAG;
  assign w_start   = r_state == S_IDLE && (i_dcache_miss || i_icache_miss);
  assign w_unused  = ^{i_icache_miss_addr[3:0], i_dcache_miss_addr[3:0]};
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE  ? (w_start ? S_ISSUE : S_IDLE) :
             w_last_rx          ? S_TAG :
             r_state == S_ISSUE ? (r_issue_cnt == 3'd7 ? S_DRAIN : S_ISSUE) :
             r_state == S_TAG   ? S_IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_blk       <= '0;
      r_grant_d   <= 1'b0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_grant_d   <= i_dcache_miss;
        r_blk       <= i_dcache_miss ? i_dcache_miss_addr[15:4] : i_icache_miss_addr[15:4];
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end else begin
        if (r_state == S_ISSUE) r_issue_cnt <= r_issue_cnt + 3'd1;
        if (w_rx) r_recv_cnt <= r_recv_cnt + 3'd1;
      end
    end
  end
  assign o_mem_enable       = r_state == S_ISSUE;
  assign o_mem_addr         = o_mem_enable ? {r_blk, r_issue_cnt, 1'b0} : '0;
  assign o_fill_data        = i_mem_data_in;
  assign o_fill_word_en     = w_rx ? 8'b1 << r_recv_cnt : '0;
  assign o_fill_index       = (w_rx || w_tag) ? r_blk[5:0] : '0;
  assign o_fill_tag         = w_tag ? {1'b1, r_blk[11:6]} : '0;
  assign o_icache_data_we   = w_rx && !r_grant_d;
  assign o_dcache_data_we   = w_rx && r_grant_d;
  assign o_icache_tag_we    = w_tag && !r_grant_d;
  assign o_dcache_tag_we    = w_tag && r_grant_d;
  assign o_icache_fill_done = w_tag && !r_grant_d;
  assign o_dcache_fill_done = w_tag && r_grant_d;
  assign o_busy             = r_state != S_IDLE;
  assign o_grant_d          = o_busy && r_grant_d;
endmodule
